// File: rtl/mem_stage_ctrl_if.sv
// Cache request/response bundle between the MEM stage and the data cache.
interface mem_stage_ctrl_if;
   logic        cache_req;
   logic        cache_wr;
   logic [15:0] cache_addr;
   logic [15:0] cache_wdata;
   logic        cache_done;
   logic [15:0] cache_rdata;

   modport master (
      output cache_req, cache_wr, cache_addr, cache_wdata,
      input  cache_done, cache_rdata
   );

   modport slave (
      input  cache_req, cache_wr, cache_addr, cache_wdata,
      output cache_done, cache_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage cache access controller: one-cycle request, stall until done or timeout.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_syn_EXMEM,
   input  logic        MemRead_syn_EXMEM,
   input  logic        MemWrite_syn_EXMEM,
   input  logic        HALT_syn_EXMEM,
   input  logic [15:0] alu_result_syn_EXMEM,
   input  logic [15:0] wdata_syn_EXMEM,
   mem_stage_ctrl_if.master cache,
   output logic [15:0] MemRead_data,
   output logic        mem_stall,
   output logic        memwb_en,
   output logic        err_mem
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic        access;
   logic        misalign;

   assign access = valid_syn_EXMEM
                 & (MemRead_syn_EXMEM | MemWrite_syn_EXMEM)
                 & ~HALT_syn_EXMEM;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = access & alu_result_syn_EXMEM[0];
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      rdata_d           = rdata_q;
      cache.cache_req   = 1'b0;
      cache.cache_wr    = 1'b0;
      cache.cache_addr  = 16'h0000;
      cache.cache_wdata = 16'h0000;
      mem_stall         = 1'b0;
      memwb_en          = 1'b0;
      err_mem           = 1'b0;
      MemRead_data      = rdata_q;
      // Outputs are gated by rst so reset silences them without waiting for a clock.
      if (rst) begin
         case (state_q)
            IDLE: begin
               if (misalign) begin
                  memwb_en     = 1'b1;
                  err_mem      = 1'b1;
                  MemRead_data = 16'h0000;
               end else if (access) begin
                  cache.cache_req   = 1'b1;
                  cache.cache_wr    = MemWrite_syn_EXMEM;
                  cache.cache_addr  = alu_result_syn_EXMEM;
                  cache.cache_wdata = wdata_syn_EXMEM;
                  mem_stall         = 1'b1;
                  cnt_d             = 8'd0;
                  state_d           = WAIT;
               end else begin
                  memwb_en = 1'b1;
               end
            end
            WAIT: begin
               if (cache.cache_done) begin
                  memwb_en = 1'b1;
                  if (MemRead_syn_EXMEM)
                     MemRead_data = cache.cache_rdata;
                  rdata_d = cache.cache_rdata;
                  cnt_d   = 8'd0;
                  state_d = IDLE;
               end else if (cnt_q == LAST) begin
                  memwb_en     = 1'b1;
                  err_mem      = 1'b1;
                  MemRead_data = 16'h0000;
                  cnt_d        = 8'd0;
                  state_d      = IDLE;
               end else begin
                  mem_stall = 1'b1;
                  cnt_d     = cnt_q + 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (default and MAX_WAIT=3 instances).
module tb_mem_stage_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid, rd, wr, halt;
   logic [15:0] addr, wdata;
   logic        done;
   logic [15:0] rdata;

   logic [15:0] rd15, rd3;
   logic        stall15, wb15, err15;
   logic        stall3, wb3, err3;

   int n_chk = 0;
   int n_fail = 0;

   mem_stage_ctrl_if c15 ();
   mem_stage_ctrl_if c3 ();

   assign c15.cache_done  = done;
   assign c15.cache_rdata = rdata;
   assign c3.cache_done   = done;
   assign c3.cache_rdata  = rdata;

   mem_stage_ctrl u15 (
      .clk(clk), .rst(rst),
      .valid_syn_EXMEM(valid), .MemRead_syn_EXMEM(rd),
      .MemWrite_syn_EXMEM(wr), .HALT_syn_EXMEM(halt),
      .alu_result_syn_EXMEM(addr), .wdata_syn_EXMEM(wdata),
      .cache(c15.master),
      .MemRead_data(rd15), .mem_stall(stall15),
      .memwb_en(wb15), .err_mem(err15)
   );

   mem_stage_ctrl #(.MAX_WAIT(3)) u3 (
      .clk(clk), .rst(rst),
      .valid_syn_EXMEM(valid), .MemRead_syn_EXMEM(rd),
      .MemWrite_syn_EXMEM(wr), .HALT_syn_EXMEM(halt),
      .alu_result_syn_EXMEM(addr), .wdata_syn_EXMEM(wdata),
      .cache(c3.master),
      .MemRead_data(rd3), .mem_stall(stall3),
      .memwb_en(wb3), .err_mem(err3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid = 0; rd = 0; wr = 0; halt = 0;
      addr = 16'h0; wdata = 16'h0; done = 0; rdata = 16'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      valid = 1; rd = 1; addr = 16'h0010;
      #2;
      n_chk++;
      if ({c15.cache_req, stall15, wb15, err15} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000",
                  {c15.cache_req, stall15, wb15, err15});
      end
      n_chk++;
      if (rd15 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0000", rd15);
      end
      tick();
      rst = 1'b1;
      idle_inputs();
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15} !== 3'b001) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b want 001",
                  {c15.cache_req, stall15, wb15});
      end
   endtask

   task automatic test_load();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0010;
      #1;
      n_chk++;
      if ({c15.cache_req, c15.cache_wr, stall15, wb15} !== 4'b1010
          || c15.cache_addr !== 16'h0010) begin
         n_fail++;
         $display("FAIL load_req: got req/wr/stall/wb %b addr %h want 1010 0010",
                  {c15.cache_req, c15.cache_wr, stall15, wb15}, c15.cache_addr);
      end
      tick();
      done = 1; rdata = 16'hBEEF;
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15, err15} !== 4'b0010
          || rd15 !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL load_done: got ctl %b data %h want 0010 BEEF",
                  {c15.cache_req, stall15, wb15, err15}, rd15);
      end
      tick();
      idle_inputs();
      #1;
      n_chk++;
      if (rd15 !== 16'hBEEF || wb15 !== 1'b1) begin
         n_fail++;
         $display("FAIL load_rdata_q: got %h wb %b want BEEF 1", rd15, wb15);
      end
   endtask

   task automatic test_store();
      int stalls = 0;
      do_reset();
      valid = 1; wr = 1; addr = 16'h0020; wdata = 16'h1234;
      for (int i = 0; i <= 5; i++) begin
         done = (i == 5);
         #1;
         if (stall15) stalls++;
         if (i == 0) begin
            n_chk++;
            if ({c15.cache_req, c15.cache_wr} !== 2'b11
                || c15.cache_wdata !== 16'h1234
                || c15.cache_addr !== 16'h0020) begin
               n_fail++;
               $display("FAIL store_req: got req/wr %b wdata %h addr %h want 11 1234 0020",
                        {c15.cache_req, c15.cache_wr}, c15.cache_wdata, c15.cache_addr);
            end
         end
         if (i == 2) begin
            n_chk++;
            if ({c15.cache_req, c15.cache_wr} !== 2'b00
                || c15.cache_wdata !== 16'h0 || c15.cache_addr !== 16'h0) begin
               n_fail++;
               $display("FAIL store_wait_quiet: got req/wr %b wdata %h addr %h want zeros",
                        {c15.cache_req, c15.cache_wr}, c15.cache_wdata, c15.cache_addr);
            end
         end
         if (i == 5) begin
            n_chk++;
            if ({stall15, wb15, err15} !== 3'b010) begin
               n_fail++;
               $display("FAIL store_done: got stall/wb/err %b want 010",
                        {stall15, wb15, err15});
            end
         end
         tick();
      end
      n_chk++;
      if (stalls !== 5) begin
         n_fail++;
         $display("FAIL store_stall_cycles: got %0d want 5", stalls);
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0040;
      for (int i = 0; i <= 3; i++) begin
         #1;
         if (i == 2) begin
            n_chk++;
            if ({stall3, wb3, err3} !== 3'b100) begin
               n_fail++;
               $display("FAIL timeout_wait: got %b want 100", {stall3, wb3, err3});
            end
         end
         if (i == 3) begin
            n_chk++;
            if ({stall3, wb3, err3} !== 3'b011 || rd3 !== 16'h0000) begin
               n_fail++;
               $display("FAIL timeout_hit: got ctl %b data %h want 011 0000",
                        {stall3, wb3, err3}, rd3);
            end
         end
         tick();
      end
      valid = 0; rd = 0; done = 1; rdata = 16'hFFFF;
      #1;
      n_chk++;
      if ({c3.cache_req, stall3, wb3, err3} !== 4'b0010 || rd3 !== 16'h0000) begin
         n_fail++;
         $display("FAIL timeout_late_done: got ctl %b data %h want 0010 0000",
                  {c3.cache_req, stall3, wb3, err3}, rd3);
      end
      tick();
      done = 0;
      #1;
      n_chk++;
      if (rd3 !== 16'h0000) begin
         n_fail++;
         $display("FAIL timeout_no_capture: got %h want 0000", rd3);
      end
      idle_inputs();
   endtask

   task automatic test_done_vs_timeout();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0050;
      tick();
      tick();
      tick();
      done = 1; rdata = 16'h5A5A;
      #1;
      n_chk++;
      if ({stall3, wb3, err3} !== 3'b010 || rd3 !== 16'h5A5A) begin
         n_fail++;
         $display("FAIL done_priority: got ctl %b data %h want 010 5A5A",
                  {stall3, wb3, err3}, rd3);
      end
      tick();
      idle_inputs();
      #1;
      n_chk++;
      if (rd3 !== 16'h5A5A) begin
         n_fail++;
         $display("FAIL done_priority_q: got %h want 5A5A", rd3);
      end
   endtask

   task automatic test_reset_midwait();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0060;
      tick();
      #1;
      n_chk++;
      if (stall15 !== 1'b1) begin
         n_fail++;
         $display("FAIL midwait_stall: got %b want 1", stall15);
      end
      rst = 1'b0;
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15, err15} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midwait_async: got %b want 0000",
                  {c15.cache_req, stall15, wb15, err15});
      end
      tick();
      rst = 1'b1;
      valid = 0; rd = 0; done = 1; rdata = 16'hAAAA;
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15} !== 3'b001 || rd15 !== 16'h0000) begin
         n_fail++;
         $display("FAIL midwait_late_done: got ctl %b data %h want 001 0000",
                  {c15.cache_req, stall15, wb15}, rd15);
      end
      tick();
      done = 0;
      #1;
      n_chk++;
      if (rd15 !== 16'h0000) begin
         n_fail++;
         $display("FAIL midwait_no_capture: got %h want 0000", rd15);
      end
      idle_inputs();
   endtask

   task automatic test_halt();
      do_reset();
      valid = 1; rd = 1; halt = 1; addr = 16'h0070;
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15} !== 3'b001) begin
         n_fail++;
         $display("FAIL halt: got req/stall/wb %b want 001",
                  {c15.cache_req, stall15, wb15});
      end
      tick();
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, wb15} !== 3'b001) begin
         n_fail++;
         $display("FAIL halt_stays_idle: got %b want 001",
                  {c15.cache_req, stall15, wb15});
      end
      idle_inputs();
   endtask

   task automatic test_misalign();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0011;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      n_chk++;
      if ({c15.cache_req, stall15, wb15, err15} !== 4'b0011
          || rd15 !== 16'h0000) begin
         n_fail++;
         $display("FAIL misalign_trap: got ctl %b data %h want 0011 0000",
                  {c15.cache_req, stall15, wb15, err15}, rd15);
      end
      tick();
      valid = 0; rd = 0;
      #1;
      n_chk++;
      if ({c15.cache_req, stall15, err15} !== 3'b000) begin
         n_fail++;
         $display("FAIL misalign_one_cycle: got %b want 000",
                  {c15.cache_req, stall15, err15});
      end
`else
      n_chk++;
      if (c15.cache_req !== 1'b1 || c15.cache_addr !== 16'h0011
          || err15 !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_pass: got req %b addr %h err %b want 1 0011 0",
                  c15.cache_req, c15.cache_addr, err15);
      end
`endif
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      valid = 1; rd = 1; addr = 16'h0100;
      tick();
      done = 1; rdata = 16'h1111;
      tick();
      done = 0; addr = 16'h0102;
      #1;
      n_chk++;
      if (c15.cache_req !== 1'b1 || c15.cache_addr !== 16'h0102
          || rd15 !== 16'h1111) begin
         n_fail++;
         $display("FAIL b2b_second_req: got req %b addr %h data %h want 1 0102 1111",
                  c15.cache_req, c15.cache_addr, rd15);
      end
      tick();
      done = 1; rdata = 16'h2222;
      #1;
      n_chk++;
      if (rd15 !== 16'h2222 || wb15 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second_done: got %h wb %b want 2222 1", rd15, wb15);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_load();
      test_store();
      test_timeout();
      test_done_vs_timeout();
      test_reset_midwait();
      test_halt();
      test_misalign();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the maximum number of WAIT-state cycles before timeout; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port valid_syn_EXMEM, input, 1, a valid instruction is present in EX/MEM.
REQ-005 SHALL have port MemRead_syn_EXMEM, input, 1, load request.
REQ-006 SHALL have port MemWrite_syn_EXMEM, input, 1, store request.
REQ-007 SHALL have port HALT_syn_EXMEM, input, 1, HALT instruction; suppresses memory access.
REQ-008 SHALL have port alu_result_syn_EXMEM, input, 16, byte address.
REQ-009 SHALL have port wdata_syn_EXMEM, input, 16, store data.
REQ-010 SHALL have cache ports: cache_req output 1; cache_wr output 1; cache_addr output 16; cache_wdata output 16; cache_done input 1; cache_rdata input 16.
REQ-011 SHALL have port MemRead_data, output, 16, load data presented to MEM/WB.
REQ-012 SHALL have port mem_stall, output, 1, freezes the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 SHALL have port memwb_en, output, 1, write enable of MEM/WB.
REQ-014 SHALL have port err_mem, output, 1, memory error travelling with the instruction.

Function
REQ-015 SHALL implement the states IDLE and WAIT, encoded as 1 bit.
REQ-016 SHALL define access = valid & (MemRead | MemWrite) & ~HALT.
REQ-017 SHALL, in IDLE when access=0, drive mem_stall=0 and memwb_en=1, with no cache request.
REQ-018 SHALL, in IDLE when access=1, drive the following combinationally for exactly one cycle: cache_req=1, cache_wr=MemWrite, cache_addr=alu_result, cache_wdata=wdata, mem_stall=1, memwb_en=0; the next state is WAIT.
REQ-019 SHALL ignore cache_done while in IDLE; the earliest completion is the cycle after the request.
REQ-020 SHALL, in WAIT, hold cache_req=0 and mem_stall=1 and increment the 8-bit wait counter each cycle until cache_done=1.
REQ-021 SHALL, in a WAIT cycle where cache_done=1, drive mem_stall=0 and memwb_en=1, drive MemRead_data=cache_rdata for loads, capture cache_rdata into rdata_q, clear the counter, and return to IDLE.
REQ-022 SHALL give a minimum load/store MEM-stage occupancy of 2 cycles, i.e. 1 stall cycle.
REQ-023 SHALL, in WAIT when counter==MAX_WAIT-1 and cache_done=0, time out: mem_stall=0, memwb_en=1, MemRead_data=16'h0000, err_mem=1 for that cycle, return to IDLE.
REQ-024 SHALL give cache_done priority over timeout when both occur in the same cycle.
REQ-025 SHALL drive MemRead_data=rdata_q in all cycles not covered by REQ-021 or REQ-023.
REQ-026 SHALL assert err_mem only in the cycle memwb_en retires the faulting instruction.
REQ-027 SHALL keep all cache outputs 0 except in request cycles.

Reset
REQ-028 SHALL, on rst low, immediately set state=IDLE, counter=0 and rdata_q=16'h0000, and force cache_req=0, mem_stall=0, memwb_en=0 and err_mem=0.
REQ-029 SHALL, on reset mid-WAIT, drop the outstanding access and ignore a late cache_done after reset release while in IDLE.
REQ-030 SHALL, on the first cycle after reset release, behave per REQ-017 or REQ-018.

Configuration
REQ-031 SHALL, when macro MEM_ALIGN_CHECK_EN is defined, treat access=1 with alu_result[0]=1 as a misaligned access: no cache_req, no stall, memwb_en=1, err_mem=1, MemRead_data=16'h0000, state stays IDLE.
REQ-032 SHALL, when MEM_ALIGN_CHECK_EN is undefined, send misaligned addresses to the cache unchanged, with err_mem set only by timeout.

Verification
REQ-033 SHALL cover: load at 0x0010, cache_done 1 cycle after request with rdata 0xBEEF -> mem_stall high 1 cycle, memwb_en pulse, MemRead_data=0xBEEF, then rdata_q=0xBEEF.
REQ-034 SHALL cover: store at 0x0020, data 0x1234, done after 4 WAIT cycles -> cache_wr=1 and cache_wdata=0x1234 in the request cycle, mem_stall high 5 cycles.
REQ-035 SHALL cover: MAX_WAIT=3 with no cache_done -> timeout after 3 WAIT cycles, err_mem=1, MemRead_data=0x0000; then cache_done on the next cycle is ignored.
REQ-036 SHALL cover: done and timeout in the same cycle -> data 0x5A5A delivered, err_mem=0.
REQ-037 SHALL cover: rst low during WAIT -> outputs zero asynchronously; HALT with MemRead=1 -> no cache_req, memwb_en=1.
REQ-038 SHALL cover, with MEM_ALIGN_CHECK_EN: load at 0x0011 -> no cache_req, err_mem=1 for one cycle; without it, cache_req issued with addr 0x0011.
